// File: rtl/can_pkg.sv
// Shared CAN receive definitions: sequencer states and default bit-timing constants.
package can_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECEIVE
  } can_state_e;

  localparam int unsigned CAN_BRP       = 16;
  localparam int unsigned CAN_SAMPLE_PT = 10;
  localparam int unsigned CAN_IDLE_BITS = 11;

endpackage

// File: rtl/can_bit_timing.sv
// RX synchroniser, time-quantum counter and sample strobe for the CAN receiver.
module can_bit_timing import can_pkg::*; #(
  parameter int unsigned BRP       = CAN_BRP,
  parameter int unsigned SAMPLE_PT = CAN_SAMPLE_PT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic hard_sync,
  input  logic resync,
  output logic rx_sync,
  output logic sync_edge,
  output logic sample
);

  localparam int unsigned TQW = $clog2(BRP);
  localparam logic [TQW-1:0] TQ_LAST = TQW'(BRP - 1);
  localparam logic [TQW-1:0] TQ_SAMPLE = TQW'(SAMPLE_PT);

  logic           sync1_q;
  logic           sync2_q;
  logic           prev_q;
  logic [TQW-1:0] tq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      tq_q    <= '0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (hard_sync || resync || tq_q == TQ_LAST)
        tq_q <= '0;
      else
        tq_q <= tq_q + 1'b1;
    end
  end

  assign rx_sync   = sync2_q;
  assign sync_edge = prev_q & ~sync2_q;
  assign sample    = (tq_q == TQ_SAMPLE);

endmodule

// File: rtl/can_rx_sequencer.sv
// CAN receive sequencer: bus-idle detection, SOF sync, bit forwarding and destuffing.
module can_rx_sequencer import can_pkg::*; #(
  parameter int unsigned BRP       = CAN_BRP,
  parameter int unsigned SAMPLE_PT = CAN_SAMPLE_PT,
  parameter int unsigned IDLE_BITS = CAN_IDLE_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic stuffing,
  input  logic done,
  output logic cap_rst,
  output logic cap_en,
  output logic rx_bit,
  output logic bus_idle,
  output logic frame_active,
  output logic stuff_err
);

  localparam int unsigned IW = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

  can_state_e    state_q, state_d;
  logic [2:0]    run_q, run_d;
  logic          last_q, last_d;
  logic          sof_q, sof_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          cap_en_d, bit_d, stuff_err_d;
  logic          hard_sync, resync;
  logic          rx_sync, sync_edge, sample;

  can_bit_timing #(
    .BRP       (BRP),
    .SAMPLE_PT (SAMPLE_PT)
  ) u_bit_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .hard_sync (hard_sync),
    .resync    (resync),
    .rx_sync   (rx_sync),
    .sync_edge (sync_edge),
    .sample    (sample)
  );

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    last_d      = last_q;
    sof_d       = sof_q;
    idle_d      = idle_q;
    cap_en_d    = 1'b0;
    bit_d       = rx_bit;
    stuff_err_d = 1'b0;
    hard_sync   = 1'b0;
    resync      = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (sample) begin
          if (!rx_sync) begin
            idle_d = '0;
          end else if (idle_q == IDLE_LAST) begin
            idle_d  = '0;
            state_d = IDLE;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      IDLE: begin
        if (sync_edge) begin
          hard_sync = 1'b1;
          sof_d     = 1'b1;
          state_d   = RECEIVE;
        end
      end
      RECEIVE: begin
        resync = sync_edge;
        if (sample) begin
          if (sof_q) begin
            sof_d = 1'b0;
            if (rx_sync) begin
              state_d = IDLE;
            end else begin
              cap_en_d = 1'b1;
              bit_d    = 1'b0;
              run_d    = 3'd1;
              last_d   = 1'b0;
            end
          end else if (stuffing && run_q == 3'd5) begin
            if (rx_sync != last_q) begin
              run_d  = 3'd1;
              last_d = rx_sync;
            end else begin
              stuff_err_d = 1'b1;
              idle_d      = '0;
              state_d     = WAIT_IDLE;
            end
          end else begin
            cap_en_d = 1'b1;
            bit_d    = rx_sync;
            if (rx_sync != last_q) begin
              run_d  = 3'd1;
              last_d = rx_sync;
            end else if (run_q != 3'd5) begin
              run_d = run_q + 3'd1;
            end
          end
        end
        // done wins over the glitch-reject return to IDLE; a stuff error pulse is kept
        if (done) begin
          idle_d  = '0;
          sof_d   = 1'b0;
          state_d = WAIT_IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_IDLE;
      run_q        <= '0;
      last_q       <= 1'b0;
      sof_q        <= 1'b0;
      idle_q       <= '0;
      cap_en       <= 1'b0;
      rx_bit       <= 1'b1;
      stuff_err    <= 1'b0;
      cap_rst      <= 1'b1;
      bus_idle     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      last_q       <= last_d;
      sof_q        <= sof_d;
      idle_q       <= idle_d;
      cap_en       <= cap_en_d;
      rx_bit       <= bit_d;
      stuff_err    <= stuff_err_d;
      cap_rst      <= (state_q != RECEIVE);
      bus_idle     <= (state_q == IDLE);
      frame_active <= (state_q == RECEIVE);
    end
  end

endmodule

// File: tb/tb_can_rx_sequencer.sv
// Self-checking bench for can_rx_sequencer: directed scenarios plus random frames vs a bit-list model.
module tb_can_rx_sequencer;

  localparam int unsigned BRP = 16;
  localparam int unsigned SP  = 10;
  localparam int unsigned IB  = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic stuffing = 1'b0;
  logic done = 1'b0;
  logic cap_rst, cap_en, rx_bit, bus_idle, frame_active, stuff_err;

  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    int unsigned t;
    logic        b;
  } ev_t;

  ev_t         cap_q[$];
  int unsigned err_q[$];
  int unsigned exp_idx[$];
  logic        exp_val[$];
  int          exp_err;

  can_rx_sequencer #(
    .BRP       (BRP),
    .SAMPLE_PT (SP),
    .IDLE_BITS (IB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .stuffing     (stuffing),
    .done         (done),
    .cap_rst      (cap_rst),
    .cap_en       (cap_en),
    .rx_bit       (rx_bit),
    .bus_idle     (bus_idle),
    .frame_active (frame_active),
    .stuff_err    (stuff_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_en) cap_q.push_back('{cyc, rx_bit});
    if (stuff_err) err_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cap_rst"}, cap_rst, 1'b1);
    check({tag, "_cap_en"}, cap_en, 1'b0);
    check({tag, "_rx_bit"}, rx_bit, 1'b1);
    check({tag, "_stuff_err"}, stuff_err, 1'b0);
    check({tag, "_bus_idle"}, bus_idle, 1'b0);
    check({tag, "_frame_active"}, frame_active, 1'b0);
  endtask

  // Reference: walk the transmitted bit list; after five equal bits the next one is
  // a stuff bit (must differ, is dropped) when stuffing is on, else a stuff error.
  function automatic void model(input logic bits[$], input logic stf);
    int   run;
    logic last;
    exp_idx.delete();
    exp_val.delete();
    exp_err = -1;
    run  = 0;
    last = 1'b0;
    for (int i = 0; i < bits.size(); i++) begin
      if (stf && run == 5) begin
        if (bits[i] == last) begin
          exp_err = i;
          return;
        end
        run  = 1;
        last = bits[i];
      end else begin
        exp_idx.push_back(i);
        exp_val.push_back(bits[i]);
        if (i > 0 && bits[i] == last) run = (run < 5) ? run + 1 : 5;
        else run = 1;
        last = bits[i];
      end
    end
  endfunction

  task automatic wait_idle(input string tag, input int unsigned min_clks);
    int unsigned w;
    w = 0;
    while (!bus_idle && w < 400) begin
      tick(1);
      w++;
    end
    check({tag, "_idle_reached"}, bus_idle, 1'b1);
    check({tag, "_idle_not_early"}, (w >= min_clks), 1'b1);
  endtask

  task automatic run_frame(input string tag, input logic bits[$], input logic stf);
    int unsigned c0, n, m;
    model(bits, stf);
    n = (exp_err >= 0) ? exp_err + 1 : bits.size();
    cap_q.delete();
    err_q.delete();
    stuffing = stf;
    @(negedge clk);
    c0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      if (i == 0) begin
        tick(3);
        check({tag, "_cap_rst_t2"}, cap_rst, 1'b1);
        tick(1);
        check({tag, "_cap_rst_t3"}, cap_rst, 1'b0);
        check({tag, "_frame_active_t3"}, frame_active, 1'b1);
        tick(12);
      end else begin
        tick(16);
      end
    end
    rx   = 1'b1;
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(1);
    check({tag, "_cap_rst_after_done"}, cap_rst, 1'b1);
    check({tag, "_frame_active_after_done"}, frame_active, 1'b0);
    check({tag, "_cap_count"}, cap_q.size(), exp_idx.size());
    m = (cap_q.size() < exp_idx.size()) ? cap_q.size() : exp_idx.size();
    for (int k = 0; k < m; k++) begin
      check({tag, "_cap_time"}, cap_q[k].t - c0, 13 + BRP * exp_idx[k]);
      check({tag, "_cap_bit"}, cap_q[k].b, exp_val[k]);
    end
    check({tag, "_err_count"}, err_q.size(), (exp_err >= 0) ? 1 : 0);
    if (exp_err >= 0 && err_q.size() > 0)
      check({tag, "_err_time"}, err_q[0] - c0, 13 + BRP * exp_err);
    stuffing = 1'b0;
    wait_idle(tag, 160);
  endtask

  initial begin
    logic fb[$];
    int unsigned len;

    // Reset state
    tick(3);
    check_reset_outputs("reset");

    // Idle detection from reset
    rst_n = 1'b1;
    for (int i = 0; i < 176; i++) begin
      tick(1);
      check("startup_cap_rst", cap_rst, 1'b1);
    end
    tick(1);
    check("startup_bus_idle_177", bus_idle, 1'b1);

    // Basic frame 0,1,0,1
    fb = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_frame("basic", fb, 1'b0);

    // Stuff bit dropped
    fb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_frame("destuff", fb, 1'b1);

    // Six equal bits -> stuff error
    fb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_frame("stuff_err", fb, 1'b1);

    // SOF glitch
    cap_q.delete();
    @(negedge clk);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    check("glitch_no_cap_en", cap_q.size(), 0);
    check("glitch_bus_idle", bus_idle, 1'b1);
    check("glitch_cap_rst", cap_rst, 1'b1);

    // Reset mid-frame
    @(negedge clk);
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset_async");
    tick(2);
    check_reset_outputs("midreset_held");
    rst_n = 1'b1;
    wait_idle("after_midreset", 160);
    fb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_frame("after_reset", fb, 1'b0);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(8, 24);
      fb.delete();
      fb.push_back(1'b0);
      for (int j = 1; j < len; j++)
        fb.push_back(($urandom % 4 == 0) ? ~fb[j-1] : fb[j-1]);
      run_frame("random", fb, 1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/can_rx_sequencer.md
CAN_RX_SEQUENCER -- requirements
Module: can_rx_sequencer

Interface
REQ-001 Parameter BRP, default 16: clocks per CAN bit time; legal range 8..256.
REQ-002 Parameter SAMPLE_PT, default 10: clock index within a bit at which rx is sampled; legal range 2..BRP-2.
REQ-003 Parameter IDLE_BITS, default 11: consecutive recessive bits that declare the bus idle.
REQ-004 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port rx  input  1: raw CAN RX line; 1 = recessive, 0 = dominant; asynchronous to clk.
REQ-007 Port stuffing  input  1: high while the capture datapath requires destuffing.
REQ-008 Port done  input  1: capture datapath has reached its final (IFS) bit.
REQ-009 Port cap_rst  output  1: active-high reset to the capture datapath.
REQ-010 Port cap_en  output  1: one-clock pulse per accepted (non-stuff) bit.
REQ-011 Port rx_bit  output  1: sampled bit value; valid whenever cap_en is high.
REQ-012 Port bus_idle  output  1: high while the bus is idle and awaiting SOF.
REQ-013 Port frame_active  output  1: high while a frame is being received.
REQ-014 Port stuff_err  output  1: one-clock pulse on a stuff-rule violation.

Function
REQ-015 rx shall pass through a 2-flop synchroniser (reset value 1); all edge detection and sampling shall use the synchronised value.
REQ-016 A time-quantum counter tq shall count 0..BRP-1 and wrap; a sample strobe shall fire when tq==SAMPLE_PT.
REQ-017 States: WAIT_IDLE, IDLE, RECEIVE; the reset state is WAIT_IDLE.
REQ-018 WAIT_IDLE: count recessive samples; a dominant sample clears the count; when the count reaches IDLE_BITS, go to IDLE.
REQ-019 IDLE: on a synchronised 1->0 edge, tq shall load 0 on the next clock (hard sync) and the state shall go to RECEIVE.
REQ-020 RECEIVE: on every synchronised 1->0 edge, tq shall load 0 (resync); there is no other phase correction.
REQ-021 RECEIVE, first sample (SOF): if recessive, return to IDLE without a cap_en pulse (glitch reject); if dominant, forward it and set the run length to 1 with value 0.
REQ-022 Forwarding: on the clock after the sample strobe, cap_en=1 and rx_bit=sample; cap_en shall first rise 13 clocks after the rx falling edge (2 sync + 10 + 1) at default parameters.
REQ-023 Run length tracking: a 3-bit run counter and a last-value bit shall be updated on every sample in RECEIVE.
REQ-024 Destuffing, when stuffing=1 and run==5:
  - opposite-value sample: discard it (no cap_en); set run=1 with the new value.
  - equal-value sample: pulse stuff_err, emit no cap_en, go to WAIT_IDLE.
REQ-025 When stuffing=0, no destuffing and no stuff errors apply; the run counter saturates at 5.
REQ-026 done=1 in RECEIVE shall move the state to WAIT_IDLE on the next clock with the recessive count cleared.
REQ-027 stuff_err and done in the same clock: stuff_err shall still pulse; the next state is WAIT_IDLE.
REQ-028 cap_rst shall be 1 in every state except RECEIVE; frame_active = (state==RECEIVE); bus_idle = (state==IDLE); all three shall be registered.
REQ-029 tq shall free-run in WAIT_IDLE so that idle bits are counted at the bit rate.

Reset
REQ-030 While rst_n=0, regardless of state or mid-frame position:
  - state=WAIT_IDLE; tq, run and idle counts = 0.
  - synchronisers=1; rx_bit=1.
  - cap_rst=1; cap_en=0; stuff_err=0; bus_idle=0; frame_active=0.
REQ-031 After rst_n deasserts, IDLE_BITS recessive bits are required before bus_idle rises.

Structure
REQ-032 The shared package can_pkg shall hold the state enum and the default BRP, SAMPLE_PT and IDLE_BITS constants.
REQ-033 The synchroniser, tq counter and sample strobe shall be one sub-module, can_bit_timing, with inputs hard-sync and resync and outputs rx_sync, edge and sample.

Verification
REQ-034 Reset, then rx=1 for 176 clocks: bus_idle rises within clock 177; cap_rst=1 throughout.
REQ-035 Idle, rx falls at t=0, then the bit pattern 0,1,0,1: cap_en pulses at t=13, 29, 45, 61 with rx_bit 0,1,0,1; cap_rst=0 from t=3.
REQ-036 stuffing=1, bits 0,0,0,0,0,1,0: exactly 6 cap_en pulses; the 1 after five 0s is dropped.
REQ-037 stuffing=1, six consecutive 0s: one stuff_err pulse, then cap_rst=1 and frame_active=0; bus_idle rises after a further 11 recessive bits.
REQ-038 rx low for 3 clocks in IDLE (SOF glitch): no cap_en; the state returns to IDLE; bus_idle=1 again.
REQ-039 rst_n pulsed low mid-frame, then done asserted in a new frame: after reset all outputs match REQ-030; after done, cap_rst=1 on the next clock.
